ram_bist: RTL and testbench

- Built-in self-test initiator for the team's dual-port `ram`. It drives the RAM's write and read ports with a March C- style sequence and compares the read-back data.
- It reports pass/fail plus the first failing address and data.
- It sits between test control logic and one `ram` instance. Both RAM clocks (`clk_write`, `clk_read`) are tied to this block's `clk`.

---
 rtl/ram_bist.sv | 156 +++++++++++++++
 tb/tb_ram_bist.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March C- style built-in self-test initiator for the dual-port ram.
// Elements: W_UP (write B ascending), RW_UP (read B / write ~B ascending),
// RW_DN (read ~B / write B descending), R_UP (read B ascending).
// Each read/compare element takes two cycles per address because the ram
// registers its read data. The first mismatch is captured and the run ends.
module ram_bist #(
    parameter int                 A_WIDTH = 5,
    parameter int                 D_WIDTH = 8,
    parameter logic [D_WIDTH-1:0] PATTERN = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [A_WIDTH-1:0] fail_address,
    output logic [D_WIDTH-1:0] fail_expected,
    output logic [D_WIDTH-1:0] fail_actual,
    output logic [A_WIDTH-1:0] address_write,
    output logic [D_WIDTH-1:0] data_write,
    output logic               write_enable,
    output logic [A_WIDTH-1:0] address_read,
    input  logic [D_WIDTH-1:0] data_read
);

    typedef enum logic [2:0] {IDLE, W_UP, RW_UP, RW_DN, R_UP, FIN} state_t;

    localparam logic [A_WIDTH-1:0] A_MAX = '1;
    localparam logic [D_WIDTH-1:0] PAT_B = PATTERN;
    localparam logic [D_WIDTH-1:0] PAT_NB = ~PATTERN;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic               phase_q, phase_d;
    logic               pass_q, pass_d;
    logic [A_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [D_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [D_WIDTH-1:0] fail_act_q, fail_act_d;
    logic [A_WIDTH-1:0] rd_hold_q;
    logic               rd_state;
    logic               mism;
    logic [D_WIDTH-1:0] expected;

    // State, address counter, result and held read address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
            rd_hold_q   <= address_read;
        end
    end

    // Next-state sequencing plus ram-side and status outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;

        rd_state = (state_q == RW_UP) || (state_q == RW_DN) || (state_q == R_UP);
        expected = (state_q == RW_DN) ? PAT_NB : PAT_B;
        // Compare only on the second cycle of an address, when read data is valid.
        mism     = rd_state && phase_q && (data_read != expected);

        busy          = (state_q == W_UP) || rd_state;
        done          = (state_q == FIN);
        pass          = pass_q;
        fail_address  = fail_addr_q;
        fail_expected = fail_exp_q;
        fail_actual   = fail_act_q;
        address_write = addr_q;
        // Present a new read address only in phase 0; otherwise hold the last one.
        address_read  = (rd_state && !phase_q) ? addr_q : rd_hold_q;
        write_enable  = 1'b0;
        data_write    = '0;

        unique case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d     = W_UP;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_act_d  = '0;
                end
            end
            W_UP: begin
                write_enable = 1'b1;
                data_write   = PAT_B;
                if (addr_q == A_MAX) begin
                    state_d = RW_UP;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            default: begin
                if (state_q == RW_UP) data_write = PAT_NB;
                if (state_q == RW_DN) data_write = PAT_B;
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (mism) begin
                    // First mismatch: record it and abandon the write of this cycle.
                    state_d     = FIN;
                    phase_d     = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = addr_q;
                    fail_exp_d  = expected;
                    fail_act_d  = data_read;
                end else begin
                    write_enable = (state_q != R_UP);
                    phase_d      = 1'b0;
                    if (state_q == RW_DN) begin
                        if (addr_q == '0) begin
                            state_d = R_UP;
                        end else begin
                            addr_d = addr_q - 1'b1;
                        end
                    end else if (addr_q == A_MAX) begin
                        if (state_q == RW_UP) begin
                            state_d = RW_DN;
                            addr_d  = A_MAX;
                        end else begin
                            state_d = FIN;
                            addr_d  = '0;
                            pass_d  = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: three instances (defaults with an optional
// stuck-at bit, PATTERN=8'hA5, A_WIDTH=1), each paired with a ram model.
module tb_ram_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] ar;
        logic [4:0] aw;
        logic [7:0] dw;
        logic       we;
    } ent_t;

    // ---------------- instance 0: defaults, fault injectable ----------------
    logic       st0 = 1'b0, busy0, done0, pass0, we0;
    logic [4:0] fa0, aw0, ar0;
    logic [7:0] fe0, fx0, dw0, rd0;
    logic [7:0] mem0 [32];
    logic       fault = 1'b0;
    ent_t       q0[$];

    ram_bist u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_address(fa0), .fail_expected(fe0), .fail_actual(fx0),
        .address_write(aw0), .data_write(dw0), .write_enable(we0),
        .address_read(ar0), .data_read(rd0)
    );

    always @(posedge clk) begin
        if (we0) mem0[aw0] <= dw0;
        rd0 <= mem0[ar0] | ((fault && ar0 == 5'd27) ? 8'h08 : 8'h00);
    end

    always @(negedge clk) if (busy0) q0.push_back('{ar0, aw0, dw0, we0});

    // ---------------- instance 1: PATTERN = 8'hA5 ----------------
    logic       st1 = 1'b0, busy1, done1, pass1, we1;
    logic [4:0] fa1, aw1, ar1;
    logic [7:0] fe1, fx1, dw1, rd1;
    logic [7:0] mem1 [32];
    ent_t       q1[$];

    ram_bist #(.A_WIDTH(5), .D_WIDTH(8), .PATTERN(8'hA5)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_address(fa1), .fail_expected(fe1), .fail_actual(fx1),
        .address_write(aw1), .data_write(dw1), .write_enable(we1),
        .address_read(ar1), .data_read(rd1)
    );

    always @(posedge clk) begin
        if (we1) mem1[aw1] <= dw1;
        rd1 <= mem1[ar1];
    end

    always @(negedge clk) if (busy1) q1.push_back('{ar1, aw1, dw1, we1});

    // ---------------- instance 2: A_WIDTH = 1 ----------------
    logic       st2 = 1'b0, busy2, done2, pass2, we2;
    logic [0:0] fa2, aw2, ar2;
    logic [7:0] fe2, fx2, dw2, rd2;
    logic [7:0] mem2 [2];

    ram_bist #(.A_WIDTH(1), .D_WIDTH(8), .PATTERN(8'h00)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_address(fa2), .fail_expected(fe2), .fail_actual(fx2),
        .address_write(aw2), .data_write(dw2), .write_enable(we2),
        .address_read(ar2), .data_read(rd2)
    );

    always @(posedge clk) begin
        if (we2) mem2[aw2] <= dw2;
        rd2 <= mem2[ar2];
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int w, input logic v);
        case (w)
            0: st0 = v;
            1: st1 = v;
            default: st2 = v;
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    // Start pulse, returning on the first negedge after the start edge.
    task automatic pulse(input int w);
        if (w == 0) q0.delete();
        if (w == 1) q1.delete();
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
    endtask

    // Count busy cycles; optionally re-pulse start at busy cycle poke_at.
    task automatic run(input int w, input int poke_at, input bit do_pulse, output int cyc);
        if (do_pulse) pulse(w);
        cyc = 0;
        while (get_busy(w) && cyc < 2000) begin
            set_start(w, cyc == poke_at);
            cyc++;
            @(negedge clk);
        end
        set_start(w, 1'b0);
    endtask

    int cyc, n, m;
    bit ok;

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_we", we0, 0);
        chk("rst_addr_data", {aw0, ar0, dw0, fa0}, 0);
        chk("rst_fail_data", {fe0, fx0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- fault-free default run ----
        run(0, -1, 1, cyc);
        chk("run0_cycles", cyc, 224);
        chk("run0_done", done0, 1);
        chk("run0_pass", pass0, 1);
        chk("run0_fail_zero", {fa0, fe0, fx0}, 0);
        ok = (q0.size() == 224);
        for (int i = 0; i < 32 && ok; i++)
            if (!(q0[i].we && q0[i].aw == 5'(i) && q0[i].dw == 8'h00)) ok = 0;
        chk("run0_wup_seq", ok, 1);
        n = 0; m = 0;
        foreach (q0[i]) begin
            if (q0[i].we) n++;
            if (q0[i].we && q0[i].dw == 8'hFF) m++;
        end
        chk("run0_writes", n, 96);
        chk("run0_writes_ff", m, 32);

        // ---- start in FIN, second start while busy ----
        pulse(0);
        chk("fin_restart_done", done0, 0);
        chk("fin_restart_pass", pass0, 0);
        chk("fin_restart_busy", busy0, 1);
        run(0, 40, 0, cyc);
        chk("poke_cycles", cyc, 224);
        chk("poke_pass", pass0, 1);

        // ---- stuck-at-1 bit 3 at address 0x1B ----
        fault = 1'b1;
        run(0, -1, 1, cyc);
        chk("flt_cycles", cyc, 88);
        chk("flt_done", done0, 1);
        chk("flt_pass", pass0, 0);
        chk("flt_addr", fa0, 5'h1B);
        chk("flt_exp", fe0, 8'h00);
        chk("flt_act", fx0, 8'h08);
        n = 0; m = 0;
        foreach (q0[i]) begin
            if (q0[i].we) n++;
            if (q0[i].we && q0[i].aw == 5'd27) m++;
        end
        chk("flt_writes", n, 59);
        chk("flt_writes_1b", m, 1);
        chk("flt_last_we", (q0.size() == 88) ? q0[87].we : 1'bx, 0);
        fault = 1'b0;

        // ---- asynchronous reset mid-run ----
        pulse(0);
        repeat (49) @(negedge clk);
        chk("mid_pre_we", we0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", we0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_done", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {busy0, done0}, 0);
        run(0, -1, 1, cyc);
        chk("post_rst_cycles", cyc, 224);
        chk("post_rst_pass", pass0, 1);

        // ---- PATTERN = A5 ----
        run(1, -1, 1, cyc);
        chk("pat_cycles", cyc, 224);
        chk("pat_pass", pass1, 1);
        n = 0; ok = 1;
        foreach (q1[i]) if (q1[i].we && q1[i].dw == 8'h5A) begin
            n++;
            if (i < 32 || i > 95) ok = 0;
        end
        chk("pat_5a_writes", n, 32);
        chk("pat_5a_in_rwup", ok, 1);
        chk("pat_rwdn_first", (q1.size() == 224) ? q1[96].ar : 5'bx, 5'h1F);
        chk("pat_rwdn_last", (q1.size() == 224) ? q1[158].ar : 5'bx, 5'h00);

        // ---- A_WIDTH = 1 ----
        run(2, -1, 1, cyc);
        chk("aw1_cycles", cyc, 14);
        chk("aw1_done_pass", {done2, pass2}, 2'b11);
        chk("aw1_fail_zero", {fa2, fe2, fx2}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
